// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator. Divides clk50 down to an output sample
// strobe and tells the downstream read pointer how far to move on each
// sample: normal (1:1), slow (stretch each source sample over ratio+1
// ticks, optionally with interpolation indices) or fast (skip ratio+1
// source samples per tick).
module sample_tick_gen #(
    parameter int BASE_DIV = 4,
    parameter int RATIO_W  = 3
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               interp,
    input  logic               is_record,
    output logic               tick,
    output logic               adv,
    output logic [RATIO_W:0]   step,
    output logic [RATIO_W-1:0] interp_idx,
    output logic               interp_en,
    output logic               running
);

    localparam int CNT_W = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RATIO_W-1:0] idx_q, idx_d;
    logic [1:0]         mode_cur_q, mode_cur_d;
    logic [RATIO_W-1:0] ratio_cur_q, ratio_cur_d;
    logic               interp_cur_q, interp_cur_d;
    logic               rec_q, rec_d;
    logic               tick_q, tick_d;
    logic               adv_q, adv_d;
    logic [RATIO_W:0]   step_q, step_d;
    logic               interp_en_q, interp_en_d;
    logic               running_q, running_d;

    logic               eff_normal_s;
    logic               rec_rise_s;
    logic               idx_at_end_s;
    logic [RATIO_W-1:0] idx_next_s;

    // is_record overrides the latched mode immediately; ratio 0 is 1:1 in any mode
    assign eff_normal_s = (mode_cur_q == 2'b00) || (mode_cur_q == 2'b11) ||
                          is_record || (ratio_cur_q == {RATIO_W{1'b0}});
    assign rec_rise_s   = is_record & ~rec_q;
    assign idx_at_end_s = (idx_q >= ratio_cur_q);

    // Next-state, counters, latched configuration and output strobes
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        mode_cur_d   = mode_cur_q;
        ratio_cur_d  = ratio_cur_q;
        interp_cur_d = interp_cur_q;
        rec_d        = is_record;
        tick_d       = 1'b0;
        adv_d        = 1'b0;
        step_d       = step_q;
        interp_en_d  = interp_en_q;
        idx_next_s   = {RATIO_W{1'b0}};

        if (stop) begin
            // stop wins over start and pause in the same cycle
            state_d     = ST_IDLE;
            cnt_d       = {CNT_W{1'b0}};
            idx_d       = {RATIO_W{1'b0}};
            step_d      = {{RATIO_W{1'b0}}, 1'b1};
            interp_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d      = ST_RUN;
                        cnt_d        = {CNT_W{1'b0}};
                        idx_d        = {RATIO_W{1'b0}};
                        mode_cur_d   = mode;
                        ratio_cur_d  = ratio;
                        interp_cur_d = interp;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    // pause is a level: counters only move while it is low
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                    end

                    if (rec_rise_s) begin
                        idx_d = {RATIO_W{1'b0}};
                    end else begin
                        idx_d = idx_q;
                    end

                    if (!pause) begin
                        if (cnt_q == CNT_LAST) begin
                            // base event: one output sample
                            cnt_d  = {CNT_W{1'b0}};
                            tick_d = 1'b1;
                            if (eff_normal_s) begin
                                idx_next_s  = {RATIO_W{1'b0}};
                                adv_d       = 1'b1;
                                step_d      = {{RATIO_W{1'b0}}, 1'b1};
                                interp_en_d = 1'b0;
                            end else if (mode_cur_q == 2'b01) begin
                                if (idx_at_end_s) begin
                                    idx_next_s = {RATIO_W{1'b0}};
                                end else begin
                                    idx_next_s = idx_q + {{(RATIO_W-1){1'b0}}, 1'b1};
                                end
                                adv_d       = idx_at_end_s;
                                step_d      = {{RATIO_W{1'b0}}, 1'b1};
                                interp_en_d = interp_cur_q;
                            end else begin
                                // fast: extra top bit keeps ratio max + 1 from overflowing
                                idx_next_s  = {RATIO_W{1'b0}};
                                adv_d       = 1'b1;
                                step_d      = {1'b0, ratio_cur_q} + {{RATIO_W{1'b0}}, 1'b1};
                                interp_en_d = 1'b0;
                            end
                            idx_d = idx_next_s;
                            // new settings only take effect at a stretch boundary
                            if (idx_next_s == {RATIO_W{1'b0}}) begin
                                mode_cur_d   = mode;
                                ratio_cur_d  = ratio;
                                interp_cur_d = interp;
                            end else begin
                                mode_cur_d   = mode_cur_q;
                                ratio_cur_d  = ratio_cur_q;
                                interp_cur_d = interp_cur_q;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = {RATIO_W{1'b0}};
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {RATIO_W{1'b0}};
            mode_cur_q   <= 2'b00;
            ratio_cur_q  <= {RATIO_W{1'b0}};
            interp_cur_q <= 1'b0;
            rec_q        <= 1'b0;
            tick_q       <= 1'b0;
            adv_q        <= 1'b0;
            step_q       <= {{RATIO_W{1'b0}}, 1'b1};
            interp_en_q  <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            mode_cur_q   <= mode_cur_d;
            ratio_cur_q  <= ratio_cur_d;
            interp_cur_q <= interp_cur_d;
            rec_q        <= rec_d;
            tick_q       <= tick_d;
            adv_q        <= adv_d;
            step_q       <= step_d;
            interp_en_q  <= interp_en_d;
            running_q    <= running_d;
        end
    end

    assign tick       = tick_q;
    assign adv        = adv_q;
    assign step       = step_q;
    assign interp_idx = idx_q;
    assign interp_en  = interp_en_q;
    assign running    = running_q;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Testbench for sample_tick_gen: directed scenarios plus random stimulus,
// all checked every cycle against a sample-level reference model.
module tb_sample_tick_gen;

    localparam int BASE_DIV = 4;
    localparam int RATIO_W  = 3;

    logic               clk50 = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               pause;
    logic [1:0]         mode;
    logic [RATIO_W-1:0] ratio;
    logic               interp;
    logic               is_record;
    logic               tick;
    logic               adv;
    logic [RATIO_W:0]   step;
    logic [RATIO_W-1:0] interp_idx;
    logic               interp_en;
    logic               running;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state: plain integers
    int m_state;      // 0 idle, 1 run, 2 paused
    int m_elapsed;    // advancing cycles since start
    int m_pos;        // position inside current stretch
    int m_mode;
    int m_ratio;
    int m_interp;
    int m_rec_prev;
    int e_tick, e_adv, e_step, e_en;

    sample_tick_gen #(.BASE_DIV(BASE_DIV), .RATIO_W(RATIO_W)) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .ratio      (ratio),
        .interp     (interp),
        .is_record  (is_record),
        .tick       (tick),
        .adv        (adv),
        .step       (step),
        .interp_idx (interp_idx),
        .interp_en  (interp_en),
        .running    (running)
    );

    always #5 clk50 = ~clk50;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // one clock edge of the reference: what the outputs must be after it
    task automatic model_edge();
        int n;
        e_tick = 0;
        e_adv  = 0;
        if (!rst_n) begin
            m_state = 0; m_elapsed = 0; m_pos = 0;
            m_mode = 0; m_ratio = 0; m_interp = 0; m_rec_prev = 0;
            e_step = 1; e_en = 0;
        end else begin
            if (stop) begin
                m_state = 0; m_elapsed = 0; m_pos = 0;
                e_step = 1; e_en = 0;
            end else if (m_state == 0) begin
                if (start) begin
                    m_state = 1; m_elapsed = 0; m_pos = 0;
                    m_mode = int'(mode); m_ratio = int'(ratio); m_interp = int'(interp);
                end
            end else begin
                if (is_record && m_rec_prev == 0) m_pos = 0;
                if (!pause) begin
                    m_elapsed++;
                    if (m_elapsed % BASE_DIV == 0) begin
                        n = m_ratio + 1;
                        e_tick = 1;
                        if (is_record || m_mode == 0 || m_mode == 3 || m_ratio == 0) begin
                            m_pos = 0; e_adv = 1; e_step = 1; e_en = 0;
                        end else if (m_mode == 1) begin
                            m_pos = (m_pos + 1) % n;
                            e_adv = (m_pos == 0) ? 1 : 0;
                            e_step = 1; e_en = m_interp;
                        end else begin
                            m_pos = 0; e_adv = 1; e_step = n; e_en = 0;
                        end
                        if (m_pos == 0) begin
                            m_mode = int'(mode); m_ratio = int'(ratio); m_interp = int'(interp);
                        end
                    end
                end
                m_state = pause ? 2 : 1;
            end
            m_rec_prev = int'(is_record);
        end
    endtask

    // advance one clock, update the model, compare on the falling edge
    task automatic cycle();
        @(posedge clk50);
        model_edge();
        @(negedge clk50);
        cyc++;
        check_eq("tick",       int'(tick),       e_tick);
        check_eq("adv",        int'(adv),        e_adv);
        check_eq("step",       int'(step),       e_step);
        check_eq("interp_idx", int'(interp_idx), m_pos);
        check_eq("interp_en",  int'(interp_en),  e_en);
        check_eq("running",    int'(running),    (m_state == 1) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    // cycles until the next tick, bounded
    task automatic wait_tick(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (tick) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 2'b00; ratio = 3'd0; interp = 1'b0; is_record = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // normal: ticks every BASE_DIV edges after start
        mode = 2'b00; ratio = 3'd3;
        pulse_start();
        wait_tick(lat);
        check_eq("first_tick_latency", lat, BASE_DIV);
        run(10);
        pulse_stop();

        // slow with interpolation, ratio 2
        mode = 2'b01; ratio = 3'd2; interp = 1'b1;
        pulse_start();
        run(30);
        pulse_stop();

        // fast at maximum ratio
        mode = 2'b10; ratio = 3'd7; interp = 1'b0;
        pulse_start();
        run(20);
        pulse_stop();

        // pause at base count 2 for 10 cycles
        mode = 2'b00; ratio = 3'd0;
        pulse_start();
        run(2);
        pause = 1'b1;
        run(10);
        pause = 1'b0;
        wait_tick(lat);
        check_eq("resume_tick_latency", lat, 2);
        run(6);
        pulse_stop();

        // ratio change 2 -> 4 mid-stretch
        mode = 2'b01; ratio = 3'd2; interp = 1'b1;
        pulse_start();
        wait_tick(lat);
        ratio = 3'd4;
        run(45);

        // is_record rising mid-stretch
        is_record = 1'b1; run(10);
        is_record = 1'b0; run(20);
        pulse_stop();

        // start and stop together from idle
        start = 1'b1; stop = 1'b1; cycle();
        start = 1'b0; stop = 1'b0;
        run(6);

        // reset mid-run
        mode = 2'b00;
        pulse_start();
        run(6);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        run(8);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) ratio = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) interp = ~interp;
            if ($urandom_range(0, 89) == 0) is_record = ~is_record;
            rst_n = ($urandom_range(0, 599) != 0);
            cycle();
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; rst_n = 1'b1;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
